// File: rtl/bit40_div.sv
// rtl/bit40_div.sv - iterative restoring divider, (QW+DW)-bit dividend by DW-bit divisor
// One quotient bit per clock; start/done handshake with divide-by-zero and overflow flags.
module bit40_div #(
  parameter int QW = 32,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [QW+DW-1:0] dividend,
  input  logic [DW-1:0]    divisor,
  output logic             ready,
  output logic             done,
  output logic [QW-1:0]    quotient,
  output logic [DW-1:0]    remainder,
  output logic             div_zero,
  output logic             ovf
);

  localparam int CW = $clog2(QW) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, stateNext;
  logic [DW-1:0]  remReg, divisorReg;
  logic [QW-1:0]  shiftReg;
  logic [CW-1:0]  count;

  logic [DW:0]    partial, diff;
  logic           qBit;
  logic [DW-1:0]  remNext;
  logic           lastIter, accept, isZero, isOvf;

  // shiftReg feeds dividend bits out of its MSB while quotient bits enter at the LSB,
  // so after QW iterations it holds the full quotient.
  always_comb begin
    partial  = {remReg, shiftReg[QW-1]};
    diff     = partial - {1'b0, divisorReg};
    qBit     = (partial >= {1'b0, divisorReg});
    remNext  = qBit ? diff[DW-1:0] : partial[DW-1:0];
    lastIter = (count == CW'(QW-1));
    accept   = (state == IDLE) && start;
    isZero   = (divisor == '0);
    isOvf    = (dividend[QW+DW-1:QW] >= divisor);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = (isZero || isOvf) ? DONE : RUN;
      RUN:  if (lastIter) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remReg     <= '0;
      divisorReg <= '0;
      shiftReg   <= '0;
      count      <= '0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      divisorReg <= divisor;
      remReg     <= dividend[QW+DW-1:QW];
      shiftReg   <= dividend[QW-1:0];
      count      <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
      if (isZero) begin
        div_zero  <= 1'b1;
        quotient  <= '0;
        remainder <= '0;
      end else if (isOvf) begin
        ovf       <= 1'b1;
        quotient  <= '0;
        remainder <= '0;
      end
    end else if (state == RUN) begin
      remReg   <= remNext;
      shiftReg <= {shiftReg[QW-2:0], qBit};
      count    <= count + CW'(1);
      if (lastIter) begin
        quotient  <= {shiftReg[QW-2:0], qBit};
        remainder <= remNext;
      end
    end
  end

endmodule

// File: tb/tb_bit40_div.sv
// tb/tb_bit40_div.sv - self-checking bench for bit40_div
// Directed vector table, handshake corner sequences and randomized checks against an arithmetic model.
module tb_bit40_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [39:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        ready, done, div_zero, ovf;
  logic [31:0] quotient;
  logic [7:0]  remainder;

  int tests = 0;
  int fails = 0;

  bit40_div #(.QW(32), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] dvd;
    logic [7:0]  dvs;
    logic [31:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values.
  task automatic model(input logic [39:0] dvd, input logic [7:0] dvs,
                       output logic [31:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    logic [63:0] qq, rr;
    dz = 0; ov = 0; q = '0; r = '0; lat = 1;
    if (dvs == 0) dz = 1;
    else begin
      qq = 64'(dvd) / 64'(dvs);
      rr = 64'(dvd) % 64'(dvs);
      if (qq > 64'hFFFF_FFFF) ov = 1;
      else begin
        q = qq[31:0]; r = rr[7:0]; lat = 33;
      end
    end
  endtask

  task automatic runOp(input logic [39:0] dvd, input logic [7:0] dvs, input bit disturb,
                       output logic [31:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    logic [31:0] prevQ;
    @(negedge clk);
    chk("ready_idle", ready, 1);
    prevQ = quotient;
    dividend = dvd; divisor = dvs; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    while (!done && lat < 60) begin
      if (disturb) begin
        chk("busy_ready_low", ready, 0);
        chk("busy_q_held", quotient, prevQ);
        if (lat >= 3 && lat <= 8) begin
          start = 1;
          dividend = {$urandom, $urandom};
          divisor = 8'($urandom);
        end else start = 0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 0;
    chk("done_ready_low", ready, 0);
    q = quotient; r = remainder; dz = div_zero; ov = ovf;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", ready, 1);
    chk("q_stable_idle", quotient, q);
  endtask

  task automatic checkOp(input string tag, input logic [39:0] dvd, input logic [7:0] dvs,
                         input logic [31:0] eq, input logic [7:0] er, input logic edz,
                         input logic eov, input bit disturb);
    logic [31:0] q; logic [7:0] r; logic dz, ov; int lat;
    runOp(dvd, dvs, disturb, q, r, dz, ov, lat);
    chk({tag, "_lat"}, 64'(lat), (edz || eov) ? 64'd1 : 64'd33);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ovf"}, ov, eov);
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] mq; logic [7:0] mr; logic mdz, mov; int mlat;
    int n, doneSeen;

    vecs[0] = '{40'h0C28F5C22D, 8'hAB, 32'h12345678, 8'h05, 1'b0, 1'b0};
    vecs[1] = '{40'hFEFFFFFFFF, 8'hFF, 32'hFFFFFFFF, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{40'h123456789A, 8'h00, 32'h0,        8'h00, 1'b1, 1'b0};
    vecs[3] = '{40'hFF00000000, 8'h10, 32'h0,        8'h00, 1'b0, 1'b1};
    vecs[4] = '{40'h1000000000, 8'h10, 32'h0,        8'h00, 1'b0, 1'b1};
    vecs[5] = '{40'h0FFFFFFFFF, 8'h10, 32'hFFFFFFFF, 8'h0F, 1'b0, 1'b0};
    vecs[6] = '{40'd1000,       8'd7,  32'd142,      8'd6,  1'b0, 1'b0};

    #2;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 7; i++)
      checkOp($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].ov, 1'b0);

    // Start and operand changes during RUN must be ignored.
    checkOp("busy", 40'h0C28F5C22D, 8'hAB, 32'h12345678, 8'h05, 1'b0, 1'b0, 1'b1);

    // Reset at iteration 10 aborts with no done.
    @(negedge clk);
    dividend = 40'h0C28F5C22D; divisor = 8'hAB; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (10) @(posedge clk);
    #1; rst_n = 0; #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_zero, 0);
    chk("abort_ovf", ovf, 0);
    @(negedge clk); rst_n = 1;
    doneSeen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) doneSeen++; end
    chk("abort_no_done", 64'(doneSeen), 0);
    checkOp("post_abort", 40'd1000, 8'd7, 32'd142, 8'd6, 1'b0, 1'b0, 1'b0);

    // start held high: back-to-back accepts every 34 cycles.
    @(negedge clk);
    dividend = 40'd1000; divisor = 8'd7; start = 1;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 100);
    start = 0;
    chk("b2b_gap", 64'(n), 34);
    chk("b2b_q", quotient, 32'd142);
    @(posedge clk); #1;
    chk("b2b_idle", ready, 1);

    // Random operands, mostly in range, some overflow or zero divisor.
    for (int i = 0; i < 150; i++) begin
      logic [39:0] d; logic [7:0] s;
      s = 8'($urandom);
      if ($urandom_range(0, 9) == 0) s = 0;
      d = {$urandom, $urandom};
      if (s != 0 && $urandom_range(0, 4) != 0) d[39:32] = 8'($urandom_range(0, int'(s) - 1));
      model(d, s, mq, mr, mdz, mov, mlat);
      checkOp($sformatf("rnd%0d", i), d, s, mq, mr, mdz, mov, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bit40_div.md
Name: bit40_div

Overview:
- Iterative restoring divider; the inverse of the team's 32x8 array multiplier.
- Divides a 40-bit dividend by an 8-bit divisor and returns a 32-bit quotient and an 8-bit remainder. A product from the multiplier divided by its B operand recovers A.
- Produces one quotient bit per clock, with a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath.

Parameters:
- QW, 32, quotient width; dividend width is QW+DW.
- DW, 8, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- dividend  input  QW+DW  dividend; captured on the accepting edge.
- divisor  input  DW  divisor; captured on the accepting edge.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  QW  quotient; held until the next accepted start.
- remainder  output  DW  remainder; held until the next accepted start.
- div_zero  output  1  divisor was 0 for the last operation.
- ovf  output  1  quotient did not fit in QW bits for the last operation.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, counter=0.
  - ready=1, done=0.
  - quotient, remainder, div_zero and ovf all 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0: capture operands; clear div_zero and ovf.
  - divisor==0: div_zero=1, quotient=0, remainder=0; go to DONE.
  - Else if dividend[QW+DW-1:QW] >= divisor: ovf=1, quotient=0, remainder=0; go to DONE.
  - Else: rem <= dividend[QW+DW-1:QW]; shift register <= dividend[QW-1:0]; counter=0; go to RUN.
- RUN, each edge:
  - p = {rem, next dividend bit, MSB first}, 9 bits (DW+1).
  - If p >= divisor: rem <= p - divisor, q bit=1.
  - Else: rem <= p[DW-1:0], q bit=0.
  - The q bit shifts into the quotient LSB.
  - After the QW-th iteration (edge E0+QW): load the quotient/remainder outputs and go to DONE.
- rem < divisor always holds, so p - divisor fits in DW bits.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency:
  - Normal case: done is high in the cycle after edge E0+32; the next start is accepted at E0+34 at the earliest.
  - Error case: done is high in the cycle after E0.
- ready=0 in RUN and DONE. Start in those states is ignored and not queued; operand changes are also ignored.
- Outputs change only on the edge entering DONE, or on reset. Results stay stable across IDLE.
- Reset during RUN aborts immediately; all outputs return to their reset values and no done is issued.
- start held high continuously: a new operation is accepted on each IDLE cycle, i.e. back-to-back every 34 cycles (normal case).
- Simultaneous events: none beyond the above; the accepting edge is the only sample point.

Test Plan:
- Normal divide: dividend=40'h0C28F5C22D, divisor=8'hAB -> done after 33 edges; quotient=32'h12345678, remainder=8'h05, ovf=0, div_zero=0.
- Max values: dividend=40'hFEFFFFFFFF, divisor=8'hFF -> quotient=32'hFFFFFFFF, remainder=8'hFE.
- Divide by zero: divisor=8'h00, any dividend -> done in the cycle after E0; div_zero=1, quotient=0, remainder=0.
- Overflow:
  - dividend=40'hFF00000000, divisor=8'h10 -> ovf=1, done after 1 edge.
  - Boundary: dividend=40'h10_00000000, divisor=8'h10 -> ovf=1.
  - Boundary: dividend=40'h0F_FFFFFFFF, divisor=8'h10 -> ovf=0, quotient=32'hFFFFFFFF, remainder=8'h0F.
- Busy handling: during RUN, pulse start with new operands and toggle the operand inputs -> ignored; first result unchanged; ready rises only after done.
- Reset mid-op: assert rst_n=0 at iteration 10 -> immediate ready=1, quotient=0, no done. A following 40'd1000 / 8'd7 gives quotient=142, remainder=6.
